wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 5, register address width.
REQ-002 SHALL have parameter DATAW, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports r0_valid / r1_valid  input  1  requester 0/1 write request valid.
REQ-006 SHALL have ports r0_ready / r1_ready  output  1  requester 0/1 request accepted this cycle.
REQ-007 SHALL have ports r0_addr / r1_addr  input  ADDRW  destination register of the request.
REQ-008 SHALL have ports r0_data / r1_data  input  DATAW  write data of the request.
REQ-009 SHALL have port wr_en  output  1  register-file write enable.
REQ-010 SHALL have port addr_d  output  ADDRW  register-file write address.
REQ-011 SHALL have port data_d  output  DATAW  register-file write data.
REQ-012 SHALL have port pend  output  2  bit i set while requester i's holding buffer is occupied.

Function
REQ-013 SHALL hold one holding buffer per requester: valid bit, address, data.
REQ-014 SHALL accept a request on a clock edge where rN_valid and rN_ready are both 1, loading it into buffer N.
REQ-015 SHALL drive rN_ready = !buf_valid[N] | grant[N] (combinational); the buffer holds one entry and is refilled in the same cycle it drains.
REQ-016 SHALL drain exactly one buffer per cycle: grant is combinational over occupied buffers; the granted buffer clears at the edge unless refilled.
REQ-017 SHALL drive wr_en = granted buffer valid & (address != 0); addr_d and data_d come from the granted buffer, and are 0 when nothing is granted.
REQ-018 SHALL drain an x0-destined entry in one cycle with wr_en = 0 (discarded, never written).
REQ-019 SHALL have latency: accepted at edge E -> wr_en high in the cycle after E, at the earliest; the register file writes at edge E+1.
REQ-020 SHALL have throughput: one write per cycle sustained; the combined accept rate cannot exceed the drain rate.
REQ-021 SHALL keep an accepted entry stable in its buffer; the requester may change its inputs after the handshake.
REQ-022 SHALL use the arbitration of REQ-029/REQ-030 when both buffers are occupied; the loser keeps its entry and deasserts ready.
REQ-023 SHALL write both requests when both target the same address, in grant order; the last granted value persists.
REQ-024 SHALL drive pend[N] = buf_valid[N].

Reset
REQ-025 SHALL, when rst_n = 0 at a rising edge, clear both buffer valid bits and set the round-robin pointer to favour requester 0.
REQ-026 SHALL, during and after reset, drive wr_en = 0, addr_d = 0, data_d = 0 and pend = 0, and drive r0_ready = r1_ready = 1 once out of reset.
REQ-027 SHALL discard buffered entries on reset mid-operation; no write is issued for them.
REQ-028 SHALL ignore requests presented at a reset edge.

Configuration
REQ-029 SHALL, with WB_ARB_RR_EN defined, grant round-robin: on contention, grant the requester not granted at the last contended cycle; the pointer updates only on contention.
REQ-030 SHALL, without WB_ARB_RR_EN, use fixed priority with requester 0 always winning; the pointer register is not built.

Structure
REQ-031 SHALL place the ADDRW/DATAW defaults and the holding-buffer record typedef (valid, addr, data) in the shared core package.
REQ-032 SHALL factor the grant logic (2-way fixed/round-robin, pointer register) into one sub-module, wb_arb_grant.

Verification
REQ-033 SHALL cover single write: r0 writes addr 5, data 0xDEADBEEF -> next cycle wr_en = 1, addr_d = 5, data_d = 0xDEADBEEF; pend = 01 for one cycle.
REQ-034 SHALL cover x0 discard: r1 writes addr 0, data 0x1234 -> wr_en stays 0, pend[1] clears after one cycle, r1_ready stays 1.
REQ-035 SHALL cover contention with RR: both write every cycle (r0 addr 1, r1 addr 2) for 6 cycles -> writes alternate 1,2,1,2...; each ready toggles.
REQ-036 SHALL cover contention without RR: same stimulus -> addr_d = 1 every cycle; r1 stalls (r1_ready = 0) until r0_valid drops, then addr 2 is written.
REQ-037 SHALL cover same-address writes: r0 and r1 target addr 7 with 0xAAAA and 0x5555 simultaneously -> two writes in grant order; a read of x7 returns the second value.
REQ-038 SHALL cover reset mid-operation: both buffers full, rst_n = 0 for one edge -> no wr_en afterwards, pend = 00, both readys = 1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the two-requester register-file write arbiter.
// The WB_ARB_RR_EN build option selects round-robin grant; it is off by default.
package wb_arbiter_pkg;

  localparam int unsigned WB_ADDRW_DEF = 5;
  localparam int unsigned WB_DATAW_DEF = 32;

  // The holding-buffer record is sized for the widest supported configuration.
  // Narrower instances zero-extend into it.
  localparam int unsigned WB_ADDRW_MAX = 16;
  localparam int unsigned WB_DATAW_MAX = 64;

  typedef struct packed {
    logic                    valid;
    logic [WB_ADDRW_MAX-1:0] addr;
    logic [WB_DATAW_MAX-1:0] data;
  } hold_buf_t;

  typedef enum logic {
    FAVOUR_R0 = 1'b0,
    FAVOUR_R1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: two write requesters plus the register-file write port.
// The slave modport belongs to the arbiter; the master modport is the surrounding system.
interface wb_arbiter_if #(
  parameter int unsigned ADDRW = wb_arbiter_pkg::WB_ADDRW_DEF,
  parameter int unsigned DATAW = wb_arbiter_pkg::WB_DATAW_DEF
) ();

  logic             r0_valid;
  logic             r1_valid;
  logic             r0_ready;
  logic             r1_ready;
  logic [ADDRW-1:0] r0_addr;
  logic [ADDRW-1:0] r1_addr;
  logic [DATAW-1:0] r0_data;
  logic [DATAW-1:0] r1_data;
  logic             wr_en;
  logic [ADDRW-1:0] addr_d;
  logic [DATAW-1:0] data_d;
  logic [1:0]       pend;

  modport master (
    output r0_valid, r1_valid, r0_addr, r1_addr, r0_data, r1_data,
    input  r0_ready, r1_ready, wr_en, addr_d, data_d, pend
  );

  modport slave (
    input  r0_valid, r1_valid, r0_addr, r1_addr, r0_data, r1_data,
    output r0_ready, r1_ready, wr_en, addr_d, data_d, pend
  );

endinterface

// File: rtl/wb_arb_grant.sv
// Two-way grant over occupied holding buffers.
// With WB_ARB_RR_EN defined, contention alternates via a pointer; otherwise requester 0 always wins.
module wb_arb_grant
  import wb_arbiter_pkg::*;
(
`ifdef WB_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef WB_ARB_RR_EN
  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  // The pointer names the requester that wins the next contended cycle.
  // It moves only when both requesters are present.
  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (&req) begin
      if (ptr_q == FAVOUR_R1) begin
        gnt   = 2'b10;
        ptr_d = FAVOUR_R0;
      end else begin
        gnt   = 2'b01;
        ptr_d = FAVOUR_R1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= FAVOUR_R0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt = req;
    if (req[0]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester write arbiter in front of a register file. It drains one holding buffer per cycle.
// An entry for x0 is consumed without a write. Building with WB_ARB_RR_EN selects round-robin grant.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDRW = WB_ADDRW_DEF,
  parameter int unsigned DATAW = WB_DATAW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);

  hold_buf_t               buf_q [2];
  hold_buf_t               buf_d [2];
  hold_buf_t               sel;
  logic [1:0]              req_valid;
  logic [WB_ADDRW_MAX-1:0] req_addr [2];
  logic [WB_DATAW_MAX-1:0] req_data [2];
  logic [1:0]              occupied;
  logic [1:0]              gnt;
  logic [1:0]              ready;

  always_comb begin
    req_valid   = {bus.r1_valid, bus.r0_valid};
    req_addr[0] = WB_ADDRW_MAX'(bus.r0_addr);
    req_addr[1] = WB_ADDRW_MAX'(bus.r1_addr);
    req_data[0] = WB_DATAW_MAX'(bus.r0_data);
    req_data[1] = WB_DATAW_MAX'(bus.r1_data);
    occupied    = {buf_q[1].valid, buf_q[0].valid};
  end

  wb_arb_grant u_grant (
`ifdef WB_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (occupied),
    .gnt   (gnt)
  );

  // A buffer accepts when it is empty or being drained this cycle.
  // A same-cycle refill overrides the drain.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i] = !buf_q[i].valid | gnt[i];
      buf_d[i] = buf_q[i];
      if (gnt[i]) begin
        buf_d[i].valid = 1'b0;
      end
      if (req_valid[i] & ready[i]) begin
        buf_d[i] = '{valid: 1'b1, addr: req_addr[i], data: req_data[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    sel = '0;
    if (rst_n) begin
      if (gnt[0]) begin
        sel = buf_q[0];
      end else if (gnt[1]) begin
        sel = buf_q[1];
      end
    end
    bus.wr_en    = sel.valid & (sel.addr != '0);
    bus.addr_d   = ADDRW'(sel.addr);
    bus.data_d   = DATAW'(sel.data);
    bus.pend     = occupied & {2{rst_n}};
    bus.r0_ready = ready[0];
    bus.r1_ready = ready[1];
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized stimulus for wb_arbiter, checked against a queue-based reference model.
// The model follows WB_ARB_RR_EN in the same way as the design.
module tb_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDRW(AW), .DATAW(DW)) bus ();

  wb_arbiter #(.ADDRW(AW), .DATAW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Each queue holds at most one entry; last_win is the winner of the latest contended cycle.
  ent_t          q0[$];
  ent_t          q1[$];
  int            last_win = 1;
  logic [DW-1:0] mdl_rf [32];
  logic [DW-1:0] obs_rf [32];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            win;
    bit            occ0, occ1, er0, er1, ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    rst_n        = rst;
    bus.r0_valid = v0;
    bus.r0_addr  = a0;
    bus.r0_data  = d0;
    bus.r1_valid = v1;
    bus.r1_addr  = a1;
    bus.r1_data  = d1;
    #1;
    occ0 = (q0.size() != 0);
    occ1 = (q1.size() != 0);
    win  = -1;
    if (occ0 && occ1)  win = RR ? ((last_win == 0) ? 1 : 0) : 0;
    else if (occ0)     win = 0;
    else if (occ1)     win = 1;
    er0 = !occ0 || (win == 0);
    er1 = !occ1 || (win == 1);
    ea  = '0;
    ed  = '0;
    if (rst && win == 0) begin
      ea = q0[0].a;
      ed = q0[0].d;
    end else if (rst && win == 1) begin
      ea = q1[0].a;
      ed = q1[0].d;
    end
    ewr = rst && (win >= 0) && (ea != 0);
    if (rst) begin
      chk({tag, ".r0_ready"}, 64'(bus.r0_ready), 64'(er0));
      chk({tag, ".r1_ready"}, 64'(bus.r1_ready), 64'(er1));
    end
    chk({tag, ".wr_en"},  64'(bus.wr_en),  64'(ewr));
    chk({tag, ".addr_d"}, 64'(bus.addr_d), 64'(ea));
    chk({tag, ".data_d"}, 64'(bus.data_d), 64'(ed));
    chk({tag, ".pend"},   64'(bus.pend),   rst ? 64'({occ1, occ0}) : 64'd0);
    if (bus.wr_en === 1'b1) obs_rf[bus.addr_d] = bus.data_d;
    @(posedge clk);
    if (!rst) begin
      q0.delete();
      q1.delete();
      last_win = 1;
    end else begin
      if (occ0 && occ1) last_win = win;
      if (win == 0) void'(q0.pop_front());
      else if (win == 1) void'(q1.pop_front());
      if (ewr) mdl_rf[ea] = ed;
      if (v0 && er0) q0.push_back('{a: a0, d: d0});
      if (v1 && er1) q1.push_back('{a: a1, d: d1});
    end
    cyc++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mdl_rf[i] = '0;
      obs_rf[i] = '0;
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    bus.r0_addr  = '0;
    bus.r1_addr  = '0;
    bus.r0_data  = '0;
    bus.r1_data  = '0;

    // Requests presented while reset is held must be dropped.
    step("reset", 1'b0, 1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    step("reset", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle("post_reset", 2);

    step("single", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    idle("single", 3);

    step("x0", 1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234);
    idle("x0", 3);

    for (int i = 0; i < 6; i++)
      step("contend", 1'b1, 1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd2, 32'h200 + 32'(i));
    for (int i = 0; i < 3; i++)
      step("contend_r1", 1'b1, 1'b0, '0, '0, 1'b1, 5'd2, 32'h2FF);
    idle("contend", 3);

    step("same_addr", 1'b1, 1'b1, 5'd7, 32'h0000_AAAA, 1'b1, 5'd7, 32'h0000_5555);
    idle("same_addr", 4);
    chk("same_addr.x7", 64'(obs_rf[7]), 64'(mdl_rf[7]));

    step("rst_mid", 1'b1, 1'b1, 5'd9, 32'hA0A0_0001, 1'b1, 5'd10, 32'hB0B0_0001);
    step("rst_mid", 1'b1, 1'b1, 5'd11, 32'hA0A0_0002, 1'b1, 5'd12, 32'hB0B0_0002);
    step("rst_mid", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle("rst_mid", 3);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 31)), $urandom);
    end
    idle("drain", 4);

    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), 64'(obs_rf[i]), 64'(mdl_rf[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
